// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter with a per-transfer timeout abort.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; fixed m0 priority otherwise.

`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [1:0]
`endif
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 2'b00
`endif
`ifndef MEM_LEN
`define MEM_LEN logic [1:0]
`endif

// state | meaning
// IDLE  | no transfer in flight; arbitrate and forward the winner combinationally
// BUSY  | transfer in flight for the latched grant; wait for s_ready or timeout
module bus_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic         clk,
   input  logic         res,
   input  logic [31:0]  m0_addr,
   input  `MEM_ACCESS_T m0_accessType,
   input  `MEM_LEN      m0_memLen,
   input  logic [31:0]  m0_wdata,
   output logic [31:0]  m0_rdata,
   output logic         m0_ready,
   output logic         m0_err,
   input  logic [31:0]  m1_addr,
   input  `MEM_ACCESS_T m1_accessType,
   input  `MEM_LEN      m1_memLen,
   input  logic [31:0]  m1_wdata,
   output logic [31:0]  m1_rdata,
   output logic         m1_ready,
   output logic         m1_err,
   output logic [31:0]  s_addr,
   output `MEM_ACCESS_T s_accessType,
   output `MEM_LEN      s_memLen,
   output logic [31:0]  s_wdata,
   input  logic [31:0]  s_rdata,
   input  logic         s_ready,
   output logic [1:0]   grant
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] LAST_COUNT = TIMEOUT - 8'd1;

   state_t     state;
   logic [7:0] counter;
   logic       m0Req;
   logic       m1Req;
   logic       pickM1;
   logic       selM1;
   logic       active;
   logic       timeoutHit;
   logic       readyAny;

   assign m0Req = (m0_accessType != `MEM_ACCESS_NONE);
   assign m1Req = (m1_accessType != `MEM_ACCESS_NONE);

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic lastM1;
   // On a tie the master that was not served last takes the bus.
   assign pickM1 = m1Req & (~m0Req | ~lastM1);
`else
   assign pickM1 = m1Req & ~m0Req;
`endif

   assign selM1  = (state == BUSY) ? grant[1] : pickM1;
   // In BUSY only the granted master counts; dropping its request aborts silently.
   assign active = (state == IDLE) ? (m0Req | m1Req) : (selM1 ? m1Req : m0Req);

   assign timeoutHit = (state == BUSY) && active && !s_ready && (counter == LAST_COUNT);
   assign readyAny   = !res && active && (s_ready || timeoutHit);

   assign s_addr       = selM1 ? m1_addr   : m0_addr;
   assign s_memLen     = selM1 ? m1_memLen : m0_memLen;
   assign s_wdata      = selM1 ? m1_wdata  : m0_wdata;
   assign s_accessType = (res || timeoutHit) ? `MEM_ACCESS_NONE
                                             : (selM1 ? m1_accessType : m0_accessType);

   assign m0_ready = readyAny & ~selM1;
   assign m1_ready = readyAny &  selM1;
   assign m0_err   = !res && timeoutHit && !selM1;
   assign m1_err   = !res && timeoutHit &&  selM1;

   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state   <= IDLE;
         grant   <= 2'b00;
         counter <= 8'd0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         lastM1  <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (active && !s_ready) begin
                  state   <= BUSY;
                  grant   <= pickM1 ? 2'b10 : 2'b01;
                  counter <= 8'd0;
               end
`ifdef BUS_ARB_ROUND_ROBIN_EN
               if (active && s_ready) begin
                  lastM1 <= pickM1;
               end
`endif
            end
            BUSY: begin
               if (!active) begin
                  state <= IDLE;
                  grant <= 2'b00;
               end else if (s_ready || timeoutHit) begin
                  state <= IDLE;
                  grant <= 2'b00;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                  lastM1 <= grant[1];
`endif
               end else begin
                  counter <= counter + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter built with TIMEOUT = 4; expectations follow BUS_ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;

   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] RD   = 2'b01;
   localparam logic [1:0] WR   = 2'b10;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        res;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [1:0]  m0_accessType, m1_accessType, m0_memLen, m1_memLen;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready, m0_err, m1_err;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  s_accessType, s_memLen;
   logic        s_ready;
   logic [1:0]  grant;

   int nChecks = 0;
   int nFails  = 0;

   bus_arbiter #(.TIMEOUT(8'd4)) dut (
      .clk(clk), .res(res),
      .m0_addr(m0_addr), .m0_accessType(m0_accessType), .m0_memLen(m0_memLen),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_addr(m1_addr), .m1_accessType(m1_accessType), .m1_memLen(m1_memLen),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
      .s_addr(s_addr), .s_accessType(s_accessType), .s_memLen(s_memLen),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      res = 1'b1;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      m0_memLen = 2'd0; m1_memLen = 2'd0; s_rdata = '0;
      m0_accessType = RD; m1_accessType = NONE; s_ready = 1'b1;

      // reset holds outputs quiet even with a request and s_ready present
      mid();
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
      check("rst_m0_err", {31'd0, m0_err}, 32'd0);
      check("rst_s_type", {30'd0, s_accessType}, {30'd0, NONE});
      cyc();
      res = 1'b0; m0_accessType = NONE; s_ready = 1'b0;
      cyc();

      // tie: both masters keep requesting, one-cycle slave
      m0_addr = 32'hA0; m1_addr = 32'hB0; m0_accessType = RD; m1_accessType = RD;
      mid();
      check("tie1_addr", s_addr, 32'hA0);
      cyc(); s_ready = 1'b1;
      mid();
      check("tie1_grant", {30'd0, grant}, 32'd1);
      check("tie1_m0_ready", {31'd0, m0_ready}, 32'd1);
      check("tie1_m1_ready", {31'd0, m1_ready}, 32'd0);
      cyc(); s_ready = 1'b0;
      mid();
      check("tie2_idle_grant", {30'd0, grant}, 32'd0);
      check("tie2_addr", s_addr, RR ? 32'hB0 : 32'hA0);
      cyc(); s_ready = 1'b1;
      mid();
      check("tie2_grant", {30'd0, grant}, RR ? 32'd2 : 32'd1);
      check("tie2_m1_ready", {31'd0, m1_ready}, RR ? 32'd1 : 32'd0);
      check("tie2_m0_ready", {31'd0, m0_ready}, RR ? 32'd0 : 32'd1);
      cyc(); s_ready = 1'b0;
      mid();
      check("tie3_addr", s_addr, 32'hA0);
      cyc(); s_ready = 1'b1;
      mid();
      check("tie3_grant", {30'd0, grant}, 32'd1);
      cyc(); s_ready = 1'b0; m0_accessType = NONE; m1_accessType = NONE;
      cyc();

      // m0 read at 0x100, slave answers in the third BUSY cycle
      m0_addr = 32'h100; m0_accessType = RD; m0_memLen = 2'd2;
      mid();
      check("rd_idle_addr", s_addr, 32'h100);
      check("rd_idle_type", {30'd0, s_accessType}, {30'd0, RD});
      check("rd_idle_grant", {30'd0, grant}, 32'd0);
      cyc();
      mid();
      check("rd_b1_grant", {30'd0, grant}, 32'd1);
      check("rd_b1_ready", {31'd0, m0_ready}, 32'd0);
      cyc();
      cyc(); s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
      mid();
      check("rd_done_ready", {31'd0, m0_ready}, 32'd1);
      check("rd_done_rdata", m0_rdata, 32'hDEADBEEF);
      check("rd_done_m1_ready", {31'd0, m1_ready}, 32'd0);
      check("rd_done_err", {31'd0, m0_err}, 32'd0);
      cyc(); s_ready = 1'b0; m0_accessType = NONE;
      mid();
      check("rd_after_grant", {30'd0, grant}, 32'd0);

      // zero-wait slave completes in IDLE without ever granting
      cyc(); m0_accessType = RD; s_ready = 1'b1;
      mid();
      check("zw_ready", {31'd0, m0_ready}, 32'd1);
      check("zw_grant", {30'd0, grant}, 32'd0);
      cyc(); m0_accessType = NONE; s_ready = 1'b0;
      mid();
      check("zw_stay_idle", {30'd0, grant}, 32'd0);

      // m1 write, m0 arrives mid-transfer and waits
      cyc();
      m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_accessType = WR; m1_memLen = 2'd3;
      mid();
      check("wr_idle_type", {30'd0, s_accessType}, {30'd0, WR});
      check("wr_idle_len", {30'd0, s_memLen}, 32'd3);
      cyc(); m0_addr = 32'h300; m0_accessType = RD;
      mid();
      check("wr_busy_grant", {30'd0, grant}, 32'd2);
      check("wr_busy_addr", s_addr, 32'h200);
      check("wr_busy_wdata", s_wdata, 32'h12345678);
      check("wr_busy_m0_ready", {31'd0, m0_ready}, 32'd0);
      cyc(); s_ready = 1'b1;
      mid();
      check("wr_done_m1_ready", {31'd0, m1_ready}, 32'd1);
      check("wr_done_m0_ready", {31'd0, m0_ready}, 32'd0);
      check("wr_done_addr", s_addr, 32'h200);
      cyc(); s_ready = 1'b0; m1_accessType = NONE;
      mid();
      check("wr_gap_grant", {30'd0, grant}, 32'd0);
      check("wr_gap_addr", s_addr, 32'h300);
      cyc(); s_ready = 1'b1;
      mid();
      check("wr_m0_grant", {30'd0, grant}, 32'd1);
      check("wr_m0_ready", {31'd0, m0_ready}, 32'd1);
      cyc(); s_ready = 1'b0; m0_accessType = NONE;
      cyc();

      // timeout with TIMEOUT = 4: fires on the fourth BUSY cycle
      m0_addr = 32'h400; m0_accessType = RD;
      cyc();
      mid();
      check("to_b1_grant", {30'd0, grant}, 32'd1);
      cyc();
      cyc();
      mid();
      check("to_b3_ready", {31'd0, m0_ready}, 32'd0);
      check("to_b3_err", {31'd0, m0_err}, 32'd0);
      cyc();
      mid();
      check("to_b4_ready", {31'd0, m0_ready}, 32'd1);
      check("to_b4_err", {31'd0, m0_err}, 32'd1);
      check("to_b4_m1_err", {31'd0, m1_err}, 32'd0);
      check("to_b4_s_type", {30'd0, s_accessType}, {30'd0, NONE});
      cyc();
      mid();
      check("to_idle_grant", {30'd0, grant}, 32'd0);
      check("to_idle_err", {31'd0, m0_err}, 32'd0);
      check("to_idle_s_type", {30'd0, s_accessType}, {30'd0, RD});

      // s_ready coinciding with the timeout cycle wins
      cyc();
      cyc();
      cyc();
      cyc(); s_ready = 1'b1;
      mid();
      check("tc_ready", {31'd0, m0_ready}, 32'd1);
      check("tc_err", {31'd0, m0_err}, 32'd0);
      cyc(); s_ready = 1'b0; m0_accessType = NONE;
      cyc();

      // granted master withdraws mid-transfer
      m0_accessType = WR;
      cyc();
      cyc(); m0_accessType = NONE;
      mid();
      check("ab_ready", {31'd0, m0_ready}, 32'd0);
      check("ab_err", {31'd0, m0_err}, 32'd0);
      check("ab_s_type", {30'd0, s_accessType}, {30'd0, NONE});
      cyc();
      mid();
      check("ab_grant", {30'd0, grant}, 32'd0);

      // reset pulse during BUSY, then re-grant of the pending request
      cyc(); m1_addr = 32'h500; m1_accessType = RD;
      cyc();
      mid();
      check("rs_busy_grant", {30'd0, grant}, 32'd2);
      cyc(); res = 1'b1; s_ready = 1'b1;
      mid();
      check("rs_grant", {30'd0, grant}, 32'd0);
      check("rs_m1_ready", {31'd0, m1_ready}, 32'd0);
      cyc(); res = 1'b0; s_ready = 1'b0;
      mid();
      check("rs_rearb_addr", s_addr, 32'h500);
      cyc(); s_ready = 1'b1;
      mid();
      check("rs_regrant", {30'd0, grant}, 32'd2);
      check("rs_m1_done", {31'd0, m1_ready}, 32'd1);
      cyc(); s_ready = 1'b0; m1_accessType = NONE;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
